// File: rtl/icache_refill.sv
// icache_refill: I-cache miss refill engine. Captures a missing PC, issues one
// AXI4 read burst for its line, collects B beats and hands the line to the cache
// as a single-cycle fill pulse. Only one refill is in flight at a time.
// Ports: clk/reset (sync, active-low); miss_req/miss_addr from fetch; busy;
//   AXI4 AR and R master channels (m_axi_*); fill_valid/fill_addr/fill_data/
//   fill_err to the cache.
// Optional: define ICACHE_REFILL_CWF_EN for critical-word-first (WRAP burst from
//   the missing word, plus cwf_valid/cwf_data early-forward ports).
module icache_refill #(
  parameter int          B        = 8,
  parameter int          b        = 3,
  parameter int          y        = 3,
  parameter logic [12:0] ARID_VAL = 13'd0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            miss_req,
  input  logic [63:0]     miss_addr,
  output logic            busy,
  output logic            m_axi_arvalid,
  input  logic            m_axi_arready,
  output logic [63:0]     m_axi_araddr,
  output logic [7:0]      m_axi_arlen,
  output logic [2:0]      m_axi_arsize,
  output logic [1:0]      m_axi_arburst,
  output logic [12:0]     m_axi_arid,
  input  logic            m_axi_rvalid,
  output logic            m_axi_rready,
  input  logic [63:0]     m_axi_rdata,
  input  logic [1:0]      m_axi_rresp,
  input  logic            m_axi_rlast,
  input  logic [12:0]     m_axi_rid,
`ifdef ICACHE_REFILL_CWF_EN
  output logic            cwf_valid,
  output logic [63:0]     cwf_data,
`endif
  output logic            fill_valid,
  output logic [63:0]     fill_addr,
  output logic [64*B-1:0] fill_data,
  output logic            fill_err
);

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_FILL} state_t;

  localparam logic [b:0] LAST_CNT = (b+1)'(B-1);

  state_t          state, state_nxt;
  logic [63:0]     line_addr;
  logic [63:0]     araddr_q;
  logic [b:0]      cnt;
  logic            err;
  logic            beat, last_beat, beat_err;
  logic [b-1:0]    start, slot;
  logic            unused;

`ifdef ICACHE_REFILL_CWF_EN
  logic [b-1:0]    word_q;
  assign start         = word_q;
  assign m_axi_arburst = 2'b10;
  assign cwf_valid     = beat && (cnt == '0);
  assign cwf_data      = m_axi_rdata;
`else
  assign start         = '0;
  assign m_axi_arburst = 2'b01;
`endif

  // Offset bits below the line (or word) boundary never reach the bus.
  assign unused = ^miss_addr[b+y-1:0];

  assign beat      = (state == S_R) && m_axi_rvalid;
  assign last_beat = (cnt == LAST_CNT);
  // Slot index wraps naturally in b bits.
  assign slot      = start + cnt[b-1:0];
  assign beat_err  = (m_axi_rresp != 2'b00) || (m_axi_rid != ARID_VAL) ||
                     (m_axi_rlast && !last_beat) || (last_beat && !m_axi_rlast);

  assign m_axi_araddr = araddr_q;
  assign m_axi_arlen  = 8'(B-1);
  assign m_axi_arsize = 3'b011;
  assign m_axi_arid   = ARID_VAL;
  assign fill_addr    = line_addr;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; a burst ends on rlast or after B beats, whichever first.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (miss_req) state_nxt = S_AR;
      S_AR:   if (m_axi_arready) state_nxt = S_R;
      S_R:    if (beat && (m_axi_rlast || last_beat)) state_nxt = S_FILL;
      S_FILL: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state only
  always_comb begin
    busy          = (state != S_IDLE);
    m_axi_arvalid = (state == S_AR);
    m_axi_rready  = (state == S_R);
    fill_valid    = (state == S_FILL);
    fill_err      = (state == S_FILL) && err;
  end

  // Datapath: line capture on accept, beat collection with sticky error.
  always_ff @(posedge clk) begin
    if (!reset) begin
      line_addr <= '0;
      araddr_q  <= '0;
      cnt       <= '0;
      err       <= 1'b0;
      fill_data <= '0;
`ifdef ICACHE_REFILL_CWF_EN
      word_q    <= '0;
`endif
    end else begin
      if (state == S_IDLE && miss_req) begin
        line_addr <= {miss_addr[63:b+y], {(b+y){1'b0}}};
`ifdef ICACHE_REFILL_CWF_EN
        araddr_q  <= {miss_addr[63:y], {y{1'b0}}};
        word_q    <= miss_addr[b+y-1:y];
`else
        araddr_q  <= {miss_addr[63:b+y], {(b+y){1'b0}}};
`endif
        cnt       <= '0;
        err       <= 1'b0;
      end
      if (beat) begin
        fill_data[int'(slot)*64 +: 64] <= m_axi_rdata;
        cnt <= cnt + 1'b1;
        if (beat_err) err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_icache_refill.sv
// tb_icache_refill: self-checking bench for icache_refill (B=8).
// A cycle table covers the zero-wait refill; hand sequences cover stalls,
// error injection, back-to-back misses and reset mid-burst.
module tb_icache_refill;
  localparam int B = 8;
`ifdef ICACHE_REFILL_CWF_EN
  localparam int          START      = 6;
  localparam logic [63:0] EXP_ARADDR = 64'h1_0230;
  localparam logic [1:0]  EXP_BURST  = 2'b10;
`else
  localparam int          START      = 0;
  localparam logic [63:0] EXP_ARADDR = 64'h1_0200;
  localparam logic [1:0]  EXP_BURST  = 2'b01;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            miss_req;
  logic [63:0]     miss_addr;
  logic            busy;
  logic            m_axi_arvalid, m_axi_arready;
  logic [63:0]     m_axi_araddr;
  logic [7:0]      m_axi_arlen;
  logic [2:0]      m_axi_arsize;
  logic [1:0]      m_axi_arburst;
  logic [12:0]     m_axi_arid;
  logic            m_axi_rvalid, m_axi_rready;
  logic [63:0]     m_axi_rdata;
  logic [1:0]      m_axi_rresp;
  logic            m_axi_rlast;
  logic [12:0]     m_axi_rid;
  logic            fill_valid, fill_err;
  logic [63:0]     fill_addr;
  logic [64*B-1:0] fill_data;
`ifdef ICACHE_REFILL_CWF_EN
  logic            cwf_valid;
  logic [63:0]     cwf_data;
`endif

  always #5 clk = ~clk;

  icache_refill dut (
    .clk(clk), .reset(reset), .miss_req(miss_req), .miss_addr(miss_addr), .busy(busy),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_araddr(m_axi_araddr),
    .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_arid(m_axi_arid), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rid(m_axi_rid),
`ifdef ICACHE_REFILL_CWF_EN
    .cwf_valid(cwf_valid), .cwf_data(cwf_data),
`endif
    .fill_valid(fill_valid), .fill_addr(fill_addr), .fill_data(fill_data), .fill_err(fill_err)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    miss_req      = 1'b0;
    miss_addr     = 64'h1_0234;
    m_axi_arready = 1'b0;
    m_axi_rvalid  = 1'b0;
    m_axi_rdata   = '0;
    m_axi_rresp   = 2'b00;
    m_axi_rlast   = 1'b0;
    m_axi_rid     = 13'd0;
  endtask

  function automatic logic [63:0] word(input int j);
    return fill_data[j*64 +: 64];
  endfunction

  typedef struct packed {
    logic        miss;
    logic        arready;
    logic        rvalid;
    logic [63:0] rdata;
    logic        rlast;
    logic        busy;
    logic        arvalid;
    logic        rready;
    logic        fvalid;
    logic        ferr;
    logic        cwf;
  } vec_t;

  vec_t vt [12];

  // Acts as AXI slave for one refill; returns after the cycle following fill_valid.
  task automatic refill(input bit hold, input int ar_wait, input bit toggle, input bit junk,
                        input int bad_resp_beat, input int last_idx, input logic [12:0] rid_v,
                        output int fills, output bit ferr, output int fcyc, output int hs);
    int k;
    int arc;
    k = 0; arc = 0; fills = 0; ferr = 1'b0; fcyc = -1; hs = 0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      miss_req      = (cyc == 0) || hold;
      miss_addr     = 64'h1_0234;
      m_axi_arready = m_axi_arvalid && (arc >= ar_wait);
      if (m_axi_arvalid) begin
        chk("ar_addr_stable", m_axi_araddr, EXP_ARADDR);
        arc++;
        if (m_axi_arready) hs++;
      end
      m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rlast = 1'b0;
      m_axi_rresp  = 2'b00; m_axi_rid = 13'd0;
      if (m_axi_rready && k < B && (!toggle || (cyc % 2) == 0)) begin
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = 64'hA000 + 64'(k);
        m_axi_rlast  = (k == last_idx);
        m_axi_rresp  = (k == bad_resp_beat) ? 2'b10 : 2'b00;
        m_axi_rid    = rid_v;
        k++;
      end else if (!m_axi_rready && junk) begin
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = 64'hDEAD;
        m_axi_rlast  = 1'b1;
      end
      if (fill_valid) begin
        fills++;
        ferr = fill_err;
        fcyc = cyc;
      end
      step();
      if (fcyc >= 0) break;
    end
    quiet_inputs();
    miss_req = hold;
  endtask

  int  fills, fcyc, hs, rst_fills;
  bit  ferr;

  initial begin
    quiet_inputs();
    reset = 1'b0;
    step(); step();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_arvalid", 64'(m_axi_arvalid), 64'd0);
    chk("rst_fill_valid", 64'(fill_valid), 64'd0);
    chk("rst_araddr", m_axi_araddr, 64'd0);
    reset = 1'b1;
    step();

    // Zero-wait refill table: miss at cycle 0, AR at 1, beats 2..9, fill at 10.
    for (int i = 0; i < 12; i++) vt[i] = '0;
    vt[0].miss = 1'b1;
    vt[1].arready = 1'b1; vt[1].busy = 1'b1; vt[1].arvalid = 1'b1;
    for (int k = 0; k < B; k++) begin
      vt[2+k].rvalid = 1'b1;
      vt[2+k].rdata  = 64'(k);
      vt[2+k].rlast  = (k == B-1);
      vt[2+k].busy   = 1'b1;
      vt[2+k].rready = 1'b1;
      vt[2+k].cwf    = (k == 0);
    end
    vt[10].busy = 1'b1; vt[10].fvalid = 1'b1;

    for (int i = 0; i < 12; i++) begin
      miss_req      = vt[i].miss;
      miss_addr     = 64'h1_0234;
      m_axi_arready = vt[i].arready;
      m_axi_rvalid  = vt[i].rvalid;
      m_axi_rdata   = vt[i].rdata;
      m_axi_rlast   = vt[i].rlast;
      #1;
      chk($sformatf("v%0d_busy", i), 64'(busy), 64'(vt[i].busy));
      chk($sformatf("v%0d_arvalid", i), 64'(m_axi_arvalid), 64'(vt[i].arvalid));
      chk($sformatf("v%0d_rready", i), 64'(m_axi_rready), 64'(vt[i].rready));
      chk($sformatf("v%0d_fill_valid", i), 64'(fill_valid), 64'(vt[i].fvalid));
      chk($sformatf("v%0d_fill_err", i), 64'(fill_err), 64'(vt[i].ferr));
`ifdef ICACHE_REFILL_CWF_EN
      chk($sformatf("v%0d_cwf_valid", i), 64'(cwf_valid), 64'(vt[i].cwf));
      if (vt[i].cwf) chk("cwf_data", cwf_data, vt[i].rdata);
`endif
      if (vt[i].arvalid) begin
        chk("araddr", m_axi_araddr, EXP_ARADDR);
        chk("arlen", 64'(m_axi_arlen), 64'd7);
        chk("arsize", 64'(m_axi_arsize), 64'd3);
        chk("arburst", 64'(m_axi_arburst), 64'(EXP_BURST));
        chk("arid", 64'(m_axi_arid), 64'd0);
      end
      if (vt[i].fvalid) chk("fill_addr", fill_addr, 64'h1_0200);
      step();
    end
    quiet_inputs();
    for (int j = 0; j < B; j++)
      chk($sformatf("line_word%0d", j), word(j), 64'((j - START) & 7));
    chk("fill_addr_hold", fill_addr, 64'h1_0200);

    // Stalled AR, every-other-cycle rvalid, junk rvalid outside R.
    refill(1'b0, 4, 1'b1, 1'b1, -1, 7, 13'd0, fills, ferr, fcyc, hs);
    chk("stall_fills", 64'(fills), 64'd1);
    chk("stall_err", 64'(ferr), 64'd0);
    chk("stall_hs", 64'(hs), 64'd1);
    for (int j = 0; j < B; j++)
      chk($sformatf("stall_word%0d", j), word(j), 64'hA000 + 64'((j - START) & 7));

    // Error injection
    refill(1'b0, 0, 1'b0, 1'b0, 3, 7, 13'd0, fills, ferr, fcyc, hs);
    chk("rresp_err", 64'(ferr), 64'd1);
    refill(1'b0, 0, 1'b0, 1'b0, -1, 5, 13'd0, fills, ferr, fcyc, hs);
    chk("early_last_err", 64'(ferr), 64'd1);
    chk("early_last_fill_cycle", 64'(fcyc), 64'd8);
    refill(1'b0, 0, 1'b0, 1'b0, -1, 7, 13'd5, fills, ferr, fcyc, hs);
    chk("rid_err", 64'(ferr), 64'd1);
    refill(1'b0, 0, 1'b0, 1'b0, -1, -1, 13'd0, fills, ferr, fcyc, hs);
    chk("no_last_err", 64'(ferr), 64'd1);
    chk("no_last_fill_cycle", 64'(fcyc), 64'd10);

    // miss_req held through and after the refill
    refill(1'b1, 0, 1'b0, 1'b0, -1, 7, 13'd0, fills, ferr, fcyc, hs);
    chk("hold_hs", 64'(hs), 64'd1);
    chk("hold_fills", 64'(fills), 64'd1);
    chk("hold_idle_after_fill", 64'(busy), 64'd0);
    step();
    chk("hold_second_ar", 64'(m_axi_arvalid), 64'd1);
    miss_req = 1'b0;

    // Reset held 3 cycles mid-burst
    m_axi_arready = 1'b1;
    step();
    m_axi_arready = 1'b0;
    m_axi_rvalid  = 1'b1;
    m_axi_rdata   = 64'hBEEF;
    step(); step();
    chk("pre_reset_rready", 64'(m_axi_rready), 64'd1);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_rready", 64'(m_axi_rready), 64'd0);
    end
    chk("midrst_fill_data", fill_data[63:0] | fill_data[64*B-1:64*B-64], 64'd0);
    chk("midrst_fill_addr", fill_addr, 64'd0);
    chk("midrst_araddr", m_axi_araddr, 64'd0);
    reset = 1'b1;
    rst_fills = 0;
    for (int c = 0; c < 12; c++) begin
      if (fill_valid || busy) rst_fills++;
      step();
    end
    m_axi_rvalid = 1'b0;
    chk("post_reset_no_fill", 64'(rst_fills), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
